ps2_keyboard: RTL



---
 rtl/ps2_keyboard_pkg.sv | 20 ++
 rtl/ps2_keyboard_if.sv | 10 +
 rtl/ps2_ascii_rom.sv | 36 +++
 rtl/ps2_keyboard.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_pkg.sv
// Shared constants for the PS/2 keyboard responder: set-2 scan codes,
// frame FSM encoding and default conditioning/timeout parameters.
package ps2_keyboard_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

endpackage

// File: rtl/ps2_keyboard_if.sv
// MEM-stage side of the keyboard responder: read strobe in, key data out.
interface ps2_keyboard_if;
  logic        ps2i_rdn;
  logic [7:0]  ps2o_scan_code;
  logic [15:0] ps2o_ascii;
  logic        ps2o_data_ready;

  modport master (output ps2i_rdn, input ps2o_scan_code, ps2o_ascii, ps2o_data_ready);
  modport slave  (input ps2i_rdn, output ps2o_scan_code, ps2o_ascii, ps2o_data_ready);
endinterface

// File: rtl/ps2_ascii_rom.sv
// Combinational set-2 scan code to ASCII lookup; unmapped codes give 0.
module ps2_ascii_rom (
  input  logic [7:0] scan_code,
  input  logic       shift,
  output logic [7:0] ascii
);
  logic [15:0] pair;  // {unshifted, shifted}

  always_comb begin
    pair = 16'h0000;
    case (scan_code)
      8'h1C: pair = {8'h61, 8'h41};  8'h32: pair = {8'h62, 8'h42};
      8'h21: pair = {8'h63, 8'h43};  8'h23: pair = {8'h64, 8'h44};
      8'h24: pair = {8'h65, 8'h45};  8'h2B: pair = {8'h66, 8'h46};
      8'h34: pair = {8'h67, 8'h47};  8'h33: pair = {8'h68, 8'h48};
      8'h43: pair = {8'h69, 8'h49};  8'h3B: pair = {8'h6A, 8'h4A};
      8'h42: pair = {8'h6B, 8'h4B};  8'h4B: pair = {8'h6C, 8'h4C};
      8'h3A: pair = {8'h6D, 8'h4D};  8'h31: pair = {8'h6E, 8'h4E};
      8'h44: pair = {8'h6F, 8'h4F};  8'h4D: pair = {8'h70, 8'h50};
      8'h15: pair = {8'h71, 8'h51};  8'h2D: pair = {8'h72, 8'h52};
      8'h1B: pair = {8'h73, 8'h53};  8'h2C: pair = {8'h74, 8'h54};
      8'h3C: pair = {8'h75, 8'h55};  8'h2A: pair = {8'h76, 8'h56};
      8'h1D: pair = {8'h77, 8'h57};  8'h22: pair = {8'h78, 8'h58};
      8'h35: pair = {8'h79, 8'h59};  8'h1A: pair = {8'h7A, 8'h5A};
      8'h16: pair = {8'h31, 8'h21};  8'h1E: pair = {8'h32, 8'h40};
      8'h26: pair = {8'h33, 8'h23};  8'h25: pair = {8'h34, 8'h24};
      8'h2E: pair = {8'h35, 8'h25};  8'h36: pair = {8'h36, 8'h5E};
      8'h3D: pair = {8'h37, 8'h26};  8'h3E: pair = {8'h38, 8'h2A};
      8'h46: pair = {8'h39, 8'h28};  8'h45: pair = {8'h30, 8'h29};
      8'h29: pair = {8'h20, 8'h20};  8'h5A: pair = {8'h0D, 8'h0D};
      8'h66: pair = {8'h08, 8'h08};
      default: pair = 16'h0000;
    endcase
    ascii = shift ? pair[7:0] : pair[15:8];
  end
endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard responder: conditions the pins, receives frames, decodes keys.
// Define PS2_PARITY_CHECK_EN to drop frames whose parity is not odd.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic          ps2i_clk,
  input  logic          ps2i_rst,
  input  logic          ps2i_ps2_clk,
  input  logic          ps2i_ps2_data,
  ps2_keyboard_if.slave mem
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic          filt_clk_q, filt_clk_d, pulse_q, pulse_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          shift_q, shift_d, brk_q, brk_d, ext_q, ext_d;
  logic [7:0]    scan_q, scan_d;
  logic [15:0]   ascii_q, ascii_d;
  logic          rdy_q, rdy_d;
  logic [7:0]    rom_ascii;
  logic          data_s, frame_ok, is_shift_key;

  assign data_s       = data_sync_q[1];
  assign is_shift_key = (shreg_q == SC_LSHIFT) || (shreg_q == SC_RSHIFT);

  ps2_ascii_rom u_rom (.scan_code(shreg_q), .shift(shift_q), .ascii(rom_ascii));

`ifndef PS2_PARITY_CHECK_EN
  logic unused_parity;
  assign unused_parity = parity_q;
`endif

  // NOTE: defaults assigned first so no path through the block infers a latch.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2i_ps2_clk};
    data_sync_d = {data_sync_q[0], ps2i_ps2_data};
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = '0;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_clk_d = clk_sync_q[1];
      else                                   filt_cnt_d = filt_cnt_q + 1'b1;
    end
    pulse_d = filt_clk_q & ~filt_clk_d;
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    parity_d = parity_q;
    frame_ok = 1'b0;
    if (state_q == ST_IDLE || pulse_q) to_cnt_d = '0;
    else                               to_cnt_d = to_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: if (pulse_q && !data_s) begin
        state_d  = ST_DATA;
        bitcnt_d = '0;
        shreg_d  = '0;
      end
      ST_DATA: if (pulse_q) begin
        shreg_d  = {data_s, shreg_q[7:1]};  // LSB arrives first
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == 3'd7) state_d = ST_PARITY;
      end
      ST_PARITY: if (pulse_q) begin
        parity_d = data_s;
        state_d  = ST_STOP;
      end
      ST_STOP: if (pulse_q) begin
        state_d  = ST_IDLE;
`ifdef PS2_PARITY_CHECK_EN
        frame_ok = data_s && (^{shreg_q, parity_q});
`else
        frame_ok = data_s;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !pulse_q && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = ST_IDLE;
      shreg_d  = '0;
      bitcnt_d = '0;
      to_cnt_d = '0;
    end
  end

  // Decode acts on the completed byte in the same cycle as the STOP pulse.
  always_comb begin
    shift_d = shift_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    scan_d  = scan_q;
    ascii_d = ascii_q;
    rdy_d   = mem.ps2i_rdn ? rdy_q : 1'b0;
    if (frame_ok) begin
      scan_d = shreg_q;
      if (shreg_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (shreg_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        if (is_shift_key) shift_d = 1'b0;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (is_shift_key && !ext_q) begin
        shift_d = 1'b1;
      end else if (ext_q) begin
        ascii_d = {8'h01, shreg_q};
        rdy_d   = 1'b1;
        ext_d   = 1'b0;
      end else if (rom_ascii != 8'h00) begin
        ascii_d = {8'h00, rom_ascii};
        rdy_d   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge ps2i_clk or negedge ps2i_rst) begin
    if (!ps2i_rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      filt_clk_q  <= 1'b0;
      filt_cnt_q  <= '0;
      pulse_q     <= 1'b0;
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      shift_q     <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      scan_q      <= '0;
      ascii_q     <= '0;
      rdy_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      pulse_q     <= pulse_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      shift_q     <= shift_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      scan_q      <= scan_d;
      ascii_q     <= ascii_d;
      rdy_q       <= rdy_d;
    end
  end

  assign mem.ps2o_scan_code  = scan_q;
  assign mem.ps2o_ascii      = ascii_q;
  assign mem.ps2o_data_ready = rdy_q;
endmodule
